// File: rtl/rx_word_assembler_if.sv
// rtl/rx_word_assembler_if.sv - UART byte input and RAM write port bundle for the word assembler
interface rx_word_assembler_if #(
    parameter int D_WL    = 24,
    parameter int WIDTH_A = 12
);
    logic [7:0]         rx_data;
    logic               rx_finish;
    logic [WIDTH_A-1:0] w_addr;
    logic [D_WL-1:0]    w_data;
    logic               w_en;

    modport slave (
        input  rx_data,
        input  rx_finish,
        output w_addr,
        output w_data,
        output w_en
    );

    modport master (
        output rx_data,
        output rx_finish,
        input  w_addr,
        input  w_data,
        input  w_en
    );
endinterface

// File: rtl/rx_word_assembler.sv
// rtl/rx_word_assembler.sv - packs UART bytes MSB-first into D_WL-bit words and writes one frame to RAM
module rx_word_assembler #(
    parameter int D_WL        = 24,
    parameter int INPUT_SIZE  = 20,
    parameter int WIDTH_A     = 12,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_x_en,
    rx_word_assembler_if.slave      bus,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    timeout_err
);
    localparam int BPW = (D_WL + 7) / 8;
    localparam int SRW = 8 * BPW;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int GCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WIDTH_A-1:0] LAST_WORD = WIDTH_A'(INPUT_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [WIDTH_A-1:0] word_cnt_q, word_cnt_d;
    logic [GCW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [SRW-1:0]     sr_q, sr_d;
    logic               w_en_q, w_en_d;
    logic [D_WL-1:0]    w_data_q, w_data_d;
    logic [WIDTH_A-1:0] w_addr_q, w_addr_d;
    logic               timeout_q, timeout_d;
    logic [SRW-1:0]     new_sr;
    logic               last_wr;

    assign new_sr  = (sr_q << 8) | SRW'(bus.rx_data);
    // The frame ends in the cycle the final word is actually presented to the RAM.
    assign last_wr = w_en_q && (w_addr_q == LAST_WORD);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sr_d       = sr_q;
        w_en_d     = 1'b0;
        w_data_d   = w_data_q;
        w_addr_d   = w_addr_q;
        timeout_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_x_en) begin
                    state_d    = S_RECV;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    gap_cnt_d  = '0;
                end
            end
            S_RECV: begin
                if (!w_x_en) begin
                    state_d = S_IDLE;
                end else if (last_wr) begin
                    state_d = S_DONE;
                end else if (bus.rx_finish) begin
                    sr_d      = new_sr;
                    gap_cnt_d = '0;
                    if (byte_cnt_q == BCW'(BPW - 1)) begin
                        w_en_d     = 1'b1;
                        w_data_d   = new_sr[D_WL-1:0];
                        w_addr_d   = word_cnt_q;
                        byte_cnt_d = '0;
                        if (word_cnt_q != LAST_WORD) begin
                            word_cnt_d = word_cnt_q + WIDTH_A'(1);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end else if (byte_cnt_q != '0) begin
                    if (gap_cnt_q == GCW'(TIMEOUT_CYC - 1)) begin
                        timeout_d  = 1'b1;
                        byte_cnt_d = '0;
                        gap_cnt_d  = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GCW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
            sr_q       <= '0;
            w_en_q     <= 1'b0;
            w_data_q   <= '0;
            w_addr_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sr_q       <= sr_d;
            w_en_q     <= w_en_d;
            w_data_q   <= w_data_d;
            w_addr_q   <= w_addr_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.w_en     = w_en_q;
    assign bus.w_data   = w_data_q;
    assign bus.w_addr   = w_addr_q;
    assign busy         = (state_q == S_RECV);
    assign frame_done   = (state_q == S_DONE);
    assign timeout_err  = timeout_q;
endmodule
